// File: rtl/wb_stage_nlane.sv
// Multi-lane writeback stage: latches an EX bundle, squashes same-bundle WAW and r0 writes,
// and retires the survivors through RF_PORTS register-file write ports, oldest lane first.
module wb_stage_nlane #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned RF_PORTS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ws_allowin,
  input  logic [LANES-1:0]         es_to_ws_valid,
  input  logic [LANES*70-1:0]      es_to_ws_bus,
  output logic [RF_PORTS*38-1:0]   ws_to_rf_bus,
  output logic                     ws_busy,
  output logic [31:0]              ws_retire_cnt
);

  localparam int unsigned CntW = $clog2(LANES + 1);

  // Held bundle state; the pc field is not needed past EX, so only dest/result are kept.
  logic                  ws_valid_q, ws_valid_d;
  logic [LANES-1:0]      valid_q, valid_d;
  logic [LANES-1:0]      pend_q, pend_d;
  logic [LANES*5-1:0]    dest_q, dest_d;
  logic [LANES*32-1:0]   res_q, res_d;
  logic [31:0]           cnt_q, cnt_d;

  logic [LANES-1:0]      in_we;
  logic [LANES*5-1:0]    in_dest;
  logic [LANES*32-1:0]   in_res;
  logic [LANES*32-1:0]   in_pc;
  logic                  unused_pc;

  logic [LANES-1:0]      cap_pend;
  logic [LANES-1:0]      sel;
  logic [CntW-1:0]       pend_cnt;
  logic [CntW-1:0]       valid_cnt;
  logic                  ws_ready_go;
  logic                  accept;
  logic [RF_PORTS*38-1:0] rf_bus;

  always_comb begin
    in_we   = '0;
    in_dest = '0;
    in_res  = '0;
    in_pc   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      in_we[i]            = es_to_ws_bus[70*i+69];
      in_dest[5*i +: 5]   = es_to_ws_bus[70*i+64 +: 5];
      in_res[32*i +: 32]  = es_to_ws_bus[70*i+32 +: 32];
      in_pc[32*i +: 32]   = es_to_ws_bus[70*i +: 32];
    end
  end

  assign unused_pc = ^in_pc;

  // A lane writes only if it targets a non-zero register that no younger lane overwrites.
  always_comb begin
    cap_pend = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (es_to_ws_valid[i] && in_we[i] && (in_dest[5*i +: 5] != 5'd0)) begin
        cap_pend[i] = 1'b1;
      end
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (es_to_ws_valid[j] && in_we[j] && (in_dest[5*j +: 5] == in_dest[5*i +: 5])) begin
          cap_pend[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    pend_cnt  = '0;
    valid_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pend_cnt  = pend_cnt + CntW'(pend_q[i]);
      valid_cnt = valid_cnt + CntW'(valid_q[i]);
    end
  end

  assign ws_ready_go = ws_valid_q && (pend_cnt <= CntW'(RF_PORTS));
  assign ws_allowin  = !ws_valid_q || ws_ready_go;
  assign accept      = ws_allowin && (|es_to_ws_valid);

  // Pack the lowest-indexed pending lanes onto ports 0..RF_PORTS-1 in lane order.
  always_comb begin
    int unsigned n;
    n      = 0;
    sel    = '0;
    rf_bus = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (ws_valid_q && pend_q[i] && (n < RF_PORTS)) begin
        rf_bus[38*n +: 38] = {1'b1, dest_q[5*i +: 5], res_q[32*i +: 32]};
        sel[i]             = 1'b1;
        n                  = n + 1;
      end
    end
  end

  always_comb begin
    ws_valid_d = ws_valid_q;
    valid_d    = valid_q;
    pend_d     = pend_q & ~sel;
    dest_d     = dest_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    if (ws_ready_go) begin
      cnt_d = cnt_q + 32'(valid_cnt);
    end
    if (ws_allowin) begin
      ws_valid_d = |es_to_ws_valid;
    end
    if (accept) begin
      valid_d = es_to_ws_valid;
      pend_d  = cap_pend;
      dest_d  = in_dest;
      res_d   = in_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ws_valid_q <= 1'b0;
      valid_q    <= '0;
      pend_q     <= '0;
      dest_q     <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      dest_q     <= dest_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ws_to_rf_bus  = rf_bus;
  assign ws_busy       = ws_valid_q;
  assign ws_retire_cnt = cnt_q;

endmodule

// File: doc/wb_stage_nlane.md
# wb_stage_nlane

Parametrised writeback stage for the multi-issue pipeline, sitting between EX and the register file. It latches a bundle of up to LANES results from EX, each lane with its own valid bit, and squashes same-bundle WAW writes and writes to r0. It then retires the remaining writes through RF_PORTS register-file write ports. When a bundle holds more writes than there are ports, it drains over several cycles and applies backpressure to EX.

## Interface

Parameters:
- LANES, default 2: issue lanes per bundle, 1..8; lane 0 is the oldest instruction.
- RF_PORTS, default 2: register-file write ports, 1..LANES.

Ports:
- clk, input, 1: the only clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset; asserted (0) clears all state immediately.
- ws_allowin, output, 1: the stage accepts a bundle this cycle.
- es_to_ws_valid, input, LANES: per-lane valid; bit i belongs to lane i.
- es_to_ws_bus, input, LANES*70: lane i occupies bits [70i+69:70i]. Each lane is {gr_we[69], dest[68:64], result[63:32], pc[31:0]}.
- ws_to_rf_bus, output, RF_PORTS*38: port p occupies bits [38p+37:38p]. Each port is {we[37], waddr[36:32], wdata[31:0]}.
- ws_busy, output, 1: a bundle is held (ws_valid).
- ws_retire_cnt, output, 32: running count of retired valid lanes.

## Operation

- **Capture.** A bundle is accepted when ws_allowin=1 and es_to_ws_valid is non-zero. On acceptance the stage latches es_to_ws_bus, latches the lane valid mask, and sets ws_valid.
  - If ws_allowin=1 and es_to_ws_valid=0, ws_valid clears and the bus registers hold their old contents.
- **Pending mask at capture.** Lane i is pending only if all of the following hold:
  - valid[i]=1 and gr_we[i]=1;
  - dest[i]≠0;
  - no younger lane j>i has valid[j], gr_we[j] and dest[j]=dest[i].
- **Per-cycle port allocation** while ws_valid=1:
  - Select the lowest-indexed pending lanes, up to RF_PORTS of them, in ascending lane order.
  - Port p carries the p-th selected lane: we=1, waddr=dest, wdata=result.
  - Unused ports drive we=0, waddr=0, wdata=0.
  - Selected lanes clear from the pending mask at the clock edge.
- **ws_ready_go** = ws_valid and (pending count ≤ RF_PORTS). This is the bundle's final drain cycle.
- **ws_allowin** = !ws_valid || ws_ready_go.
- **Completion.** Completion is the cycle in which ws_valid=1 and ws_ready_go=1.
  - ws_retire_cnt adds popcount(valid mask), including lanes that do not write.
  - The counter wraps modulo 2^32.
- **Back-to-back bundles.** A new bundle may be captured in the completion cycle of the previous one. The new bundle's pending mask replaces the old one.
- **Idle or reset outputs.** When ws_valid=0, every port drives we=0.
- **Reset** (reset=0, at any time including mid-drain):
  - ws_valid=0, pending mask=0, valid mask=0, ws_retire_cnt=0.
  - ws_busy=0, ws_allowin=1, all ws_to_rf_bus bits 0.
  - Undrained writes are discarded.

## Timing

- Write latency is 1 cycle: a bundle captured at edge N drives its first port writes during cycle N+1 (combinational from registers).
- Drain length in cycles = max(1, ceil(P/RF_PORTS)), where P is the pending count at capture.
- ws_allowin is 0 during every non-final drain cycle. EX must hold its bus and valid stable while ws_allowin=0.
- A bundle with P=0 (no writes, or only r0 or squashed writes) occupies exactly 1 cycle.
- With LANES=RF_PORTS=2, all-valid bundles retire 1 per cycle with ws_allowin constantly 1.
- ws_retire_cnt updates at the completion edge and is visible the following cycle.
- Reset deassertion takes effect at the next rising edge; the first capture can happen at that edge.

## Test plan

- **Basic dual lane.** LANES=2, RF_PORTS=2. Lane 0 writes r1=0x11 and lane 1 writes r2=0x22, both valid.
  - Next cycle: port 0 = {1,1,0x11}, port 1 = {1,2,0x22}; ws_allowin=1.
  - ws_retire_cnt=2 one cycle later.
- **Partial valid.** LANES=2. valid=2'b10 with lane 1 writing r5=0xABCD.
  - Port 0 = {1,5,0xABCD} and port 1 we=0; count +1.
  - A lane-0-only bundle must not be dropped.
- **WAW and r0.** LANES=4, RF_PORTS=2. Lanes 0–3 write r3=1, r3=2, r0=7, r4=9.
  - Pending lanes are 1 and 3 only. One cycle: port 0 = {1,3,2}, port 1 = {1,4,9}.
  - ws_allowin=1; count +4.
- **Multi-cycle drain.** LANES=4, RF_PORTS=1. Lanes write r1..r4 = 0xA..0xD, with EX presenting a second bundle held stable.
  - Four cycles of port 0 writes in the order r1, r2, r3, r4; ws_allowin=0,0,0,1.
  - The second bundle is captured on the 4th cycle's edge and its writes start the next cycle.
- **Reset mid-drain.** Same 4-lane bundle as the multi-cycle drain. Assert reset=0 asynchronously after the 2nd write.
  - ws_to_rf_bus=0, ws_busy=0, ws_retire_cnt=0 immediately, with no further writes after release.
- **Counter wrap.** Preload the counter with 2^32-1 retirements, then retire a 2-lane bundle.
  - ws_retire_cnt=1.
